// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude-compare sequencer driving an external 1-bit comparator slice, MSB first.
// Latency: accept edge to res_valid is WIDTH+1 edges, or k+1 with EARLY_EXIT. Backpressure: res_valid holds until res_ready; start_ready only in IDLE.
module serial_cmp_ctrl #(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_err,
    output logic             busy,
    output logic             cmp_a,
    output logic             cmp_b,
    output logic             cmp_c1,
    output logic             cmp_c0,
    input  logic             cmp_z1,
    input  logic             cmp_z0
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       casc_q, casc_d;
    logic             err_q, err_d;
    logic             start_ready_q, start_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             res_gt_q, res_gt_d, res_lt_q, res_lt_d, res_eq_q, res_eq_d;
    logic             res_err_q, res_err_d;
    logic             busy_q, busy_d;
    logic             cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic [1:0]       cmp_c_q, cmp_c_d;
    logic [1:0]       z;

    assign z = {cmp_z1, cmp_z0};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        casc_d  = casc_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = IW'(WIDTH - 1);
                    casc_d  = 2'b00;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // An illegal 11 is stored and fed forward untouched; only the sticky flag records it.
                casc_d = z;
                err_d  = err_q | (z == 2'b11);
                if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end
                if ((idx_q == '0) || (EARLY_EXIT && ((z == 2'b10) || (z == 2'b01)))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next state so they leave the flops aligned with the state.
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        res_valid_d   = (state_d == DONE);
        res_gt_d      = (state_d == DONE) && (casc_d == 2'b10);
        res_lt_d      = (state_d == DONE) && (casc_d == 2'b01);
        res_eq_d      = (state_d == DONE) && (casc_d == 2'b00);
        res_err_d     = (state_d == DONE) && err_d;
        cmp_a_d       = (state_d == RUN) ? a_d[idx_d] : 1'b0;
        cmp_b_d       = (state_d == RUN) ? b_d[idx_d] : 1'b0;
        cmp_c_d       = (state_d == RUN) ? casc_d : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            idx_q         <= '0;
            casc_q        <= 2'b00;
            err_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            res_gt_q      <= 1'b0;
            res_lt_q      <= 1'b0;
            res_eq_q      <= 1'b0;
            res_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            cmp_a_q       <= 1'b0;
            cmp_b_q       <= 1'b0;
            cmp_c_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            idx_q         <= idx_d;
            casc_q        <= casc_d;
            err_q         <= err_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            res_gt_q      <= res_gt_d;
            res_lt_q      <= res_lt_d;
            res_eq_q      <= res_eq_d;
            res_err_q     <= res_err_d;
            busy_q        <= busy_d;
            cmp_a_q       <= cmp_a_d;
            cmp_b_q       <= cmp_b_d;
            cmp_c_q       <= cmp_c_d;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign res_gt      = res_gt_q;
    assign res_lt      = res_lt_q;
    assign res_eq      = res_eq_q;
    assign res_err     = res_err_q;
    assign busy        = busy_q;
    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign cmp_c1      = cmp_c_q[1];
    assign cmp_c0      = cmp_c_q[0];

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl: instance 0 runs full-width, instance 1 exits early; each drives a behavioural slice.
module tb_serial_cmp_ctrl;
    localparam int W = 4;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        logic err;
        int   lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid [2];
    logic         start_ready [2];
    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    logic         res_valid [2];
    logic         res_ready [2];
    logic         res_gt [2], res_lt [2], res_eq [2], res_err [2], busy [2];
    logic         cmp_a [2], cmp_b [2], cmp_c1 [2], cmp_c0 [2], cmp_z1 [2], cmp_z0 [2];
    logic         inj_now [2];

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q [$];

    function automatic logic [1:0] slice_fn(input logic a, input logic b, input logic [1:0] c, input bit inj);
        if (inj) return 2'b11;
        if (c != 2'b00) return c;
        if (a && !b) return 2'b10;
        if (!a && b) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int inj, input bit ee);
        exp_t       m;
        logic [1:0] c;
        c     = 2'b00;
        m.err = 1'b0;
        m.lat = W + 1;
        for (int i = W - 1; i >= 0; i--) begin
            c = slice_fn(a[i], b[i], c, i == inj);
            if (c == 2'b11) m.err = 1'b1;
            if (ee && (c == 2'b10 || c == 2'b01)) begin
                m.lat = W - i + 1;
                break;
            end
        end
        m.gt = (c == 2'b10);
        m.lt = (c == 2'b01);
        m.eq = (c == 2'b00);
        return m;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        serial_cmp_ctrl #(.WIDTH(W), .EARLY_EXIT(g == 1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_valid(start_valid[g]),
            .start_ready(start_ready[g]),
            .op_a       (op_a[g]),
            .op_b       (op_b[g]),
            .res_valid  (res_valid[g]),
            .res_ready  (res_ready[g]),
            .res_gt     (res_gt[g]),
            .res_lt     (res_lt[g]),
            .res_eq     (res_eq[g]),
            .res_err    (res_err[g]),
            .busy       (busy[g]),
            .cmp_a      (cmp_a[g]),
            .cmp_b      (cmp_b[g]),
            .cmp_c1     (cmp_c1[g]),
            .cmp_c0     (cmp_c0[g]),
            .cmp_z1     (cmp_z1[g]),
            .cmp_z0     (cmp_z0[g])
        );
        assign {cmp_z1[g], cmp_z0[g]} = slice_fn(cmp_a[g], cmp_b[g], {cmp_c1[g], cmp_c0[g]}, inj_now[g]);
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_res(input int sel, input exp_t e);
        chk("res_valid", 32'(res_valid[sel]), 32'd1);
        chk("res_gt", 32'(res_gt[sel]), 32'(e.gt));
        chk("res_lt", 32'(res_lt[sel]), 32'(e.lt));
        chk("res_eq", 32'(res_eq[sel]), 32'(e.eq));
        chk("res_err", 32'(res_err[sel]), 32'(e.err));
        chk("start_ready_done", 32'(start_ready[sel]), 32'd0);
    endtask

    // Called and returning on a negedge; keep=1 leaves start_valid high with the next operands.
    task automatic do_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b, input int inj,
                         input int hold, input bit keep, input logic [W-1:0] na, input logic [W-1:0] nb);
        exp_t       e;
        int         waits, edges, cyc, bitn;
        logic [1:0] ec;
        bit         pre;
        q.push_back(model(a, b, inj, sel == 1));
        pre              = start_valid[sel];
        start_valid[sel] = 1'b1;
        op_a[sel]        = a;
        op_b[sel]        = b;
        waits            = 0;
        while (!start_ready[sel] && waits < 20) begin
            @(posedge clk);
            @(negedge clk);
            waits++;
        end
        chk("start_ready", 32'(start_ready[sel]), 32'd1);
        if (pre) chk("accept_first_idle", 32'(waits), 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (keep) begin
            op_a[sel] = na;
            op_b[sel] = nb;
        end else begin
            start_valid[sel] = 1'b0;
        end
        edges = 1;
        cyc   = 0;
        ec    = 2'b00;
        while (!res_valid[sel]) begin
            if (cyc >= W) begin
                chk("run_overrun", 32'(cyc), 32'(W - 1));
                break;
            end
            bitn = W - 1 - cyc;
            chk("busy_run", 32'(busy[sel]), 32'd1);
            chk("start_ready_run", 32'(start_ready[sel]), 32'd0);
            chk("cmp_a", 32'(cmp_a[sel]), 32'(a[bitn]));
            chk("cmp_b", 32'(cmp_b[sel]), 32'(b[bitn]));
            chk("cmp_c", 32'({cmp_c1[sel], cmp_c0[sel]}), 32'(ec));
            inj_now[sel] = (bitn == inj);
            ec = slice_fn(a[bitn], b[bitn], ec, bitn == inj);
            @(posedge clk);
            @(negedge clk);
            inj_now[sel] = 1'b0;
            edges++;
            cyc++;
        end
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk("latency", 32'(edges), 32'(e.lat));
        for (int h = 0; h < hold; h++) begin
            chk_res(sel, e);
            @(posedge clk);
            @(negedge clk);
        end
        chk_res(sel, e);
        res_ready[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready[sel] = 1'b0;
        chk("res_valid_after", 32'(res_valid[sel]), 32'd0);
        chk("start_ready_after", 32'(start_ready[sel]), 32'd1);
        chk("busy_after", 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_valid[i] = 1'b0;
            op_a[i]        = '0;
            op_b[i]        = '0;
            res_ready[i]   = 1'b0;
            inj_now[i]     = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_start_ready", 32'(start_ready[i]), 32'd1);
            chk("rst_res_valid", 32'(res_valid[i]), 32'd0);
            chk("rst_res_flags", 32'({res_gt[i], res_lt[i], res_eq[i], res_err[i]}), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_cmp", 32'({cmp_a[i], cmp_b[i], cmp_c1[i], cmp_c0[i]}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 4'b1010, 4'b0110, -1, 0, 1'b0, '0, '0);
        do_op(1, 4'b0011, 4'b0101, -1, 0, 1'b0, '0, '0);
        do_op(0, 4'b1111, 4'b1111, -1, 4, 1'b0, '0, '0);
        do_op(0, 4'b0101, 4'b0101, 1, 0, 1'b0, '0, '0);
        do_op(0, 4'b0001, 4'b0000, -1, 0, 1'b0, '0, '0);

        // Abort in the second RUN cycle.
        start_valid[0] = 1'b1;
        op_a[0]        = 4'b1001;
        op_b[0]        = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        start_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_start_ready", 32'(start_ready[0]), 32'd1);
        chk("arst_cmp", 32'({cmp_a[0], cmp_b[0], cmp_c1[0], cmp_c0[0]}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_res_valid", 32'(res_valid[0]), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_res_valid", 32'(res_valid[0]), 32'd0);
        end
        do_op(0, 4'b0100, 4'b0100, -1, 0, 1'b0, '0, '0);

        do_op(1, 4'b1000, 4'b0000, -1, 2, 1'b1, 4'b0110, 4'b0101);
        do_op(1, 4'b0110, 4'b0101, -1, 0, 1'b0, '0, '0);

        for (int i = 0; i < 8; i++) begin
            do_op(i % 2, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), -1,
                  int'($urandom_range(0, 2)), 1'b0, '0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_cmp_ctrl.md
# serial_cmp_ctrl

Bit-serial magnitude-compare sequencer for the ALU's 1-bit comparator slice (inputs A, B, cascade C1/C0; outputs Z1/Z0). It latches two WIDTH-bit operands behind a valid/ready handshake and feeds the slice one bit pair per clock, MSB first. Each cycle it registers the slice's Z1/Z0 back into C1/C0. The final GT/LT/EQ result is presented behind a second valid/ready handshake. The slice stays external and combinational; this block is its only driver.

## Interface
- WIDTH, 4: operand width in bits, ≥2.
- EARLY_EXIT, 1: 1 ends RUN on the first non-equal cascade code; 0 always runs WIDTH cycles.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  requester presents operands
- start_ready  out  1  block can accept operands (IDLE only)
- op_a  in  WIDTH  operand A, unsigned
- op_b  in  WIDTH  operand B, unsigned
- res_valid  out  1  result available (DONE only)
- res_ready  in  1  consumer takes result
- res_gt / res_lt / res_eq  out  1 each  one-hot result, valid while res_valid
- res_err  out  1  slice returned illegal code 11 during this operation
- busy  out  1  high in RUN or DONE
- cmp_a, cmp_b  out  1  current bit of latched A, B to slice
- cmp_c1, cmp_c0  out  1  cascade register to slice
- cmp_z1, cmp_z0  in  1  slice outputs

## Operation
- Cascade code {C1,C0} and {Z1,Z0}: 00 equal so far, 10 A>B, 01 A<B, 11 illegal.
- States:
  - IDLE: start_ready=1. start_valid&start_ready latches op_a/op_b, sets idx=WIDTH-1, clears cascade reg to 00 and err, and moves to RUN.
  - RUN: cmp_a=a_q[idx], cmp_b=b_q[idx], {cmp_c1,cmp_c0}=cascade reg. Each edge: cascade reg <= {cmp_z1,cmp_z0}; err |= (Z==11); idx decrements.
    - Leave to DONE after the idx==0 edge.
    - With EARLY_EXIT=1, also leave to DONE when the registered Z is 10 or 01.
  - DONE: res_valid=1. Outputs are decoded from the cascade reg: 10→gt, 01→lt, 00→eq, 11→eq=0,gt=0,lt=0 with res_err=1. res_valid&res_ready returns to IDLE.
- res_err is sticky for the operation. An 11 code is still written to the cascade reg and fed forward; the slice's handling of it is not corrected.
- idx is a $clog2(WIDTH)-bit down-counter. It never wraps, because RUN exits at 0.
- In IDLE, cmp_a/cmp_b/cmp_c1/cmp_c0 are driven 0.
- Operands latched in IDLE are held constant through RUN/DONE. Changes on op_a/op_b after acceptance are ignored.
- start_valid in RUN/DONE is not accepted (start_ready=0). The requester must hold it until accepted.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, start_ready=1, res_valid=0.
  - res_gt=res_lt=res_eq=res_err=0, busy=0.
  - cascade reg=00, idx=0, cmp_* outputs=0.
- Reset mid-RUN or mid-DONE aborts immediately. The pending result is lost and no res_valid pulse is produced.
- Latency, accept edge to res_valid high:
  - EARLY_EXIT=0: WIDTH+1 edges.
  - EARLY_EXIT=1: k+1 edges, where k is the number of bits from the MSB down to and including the first differing bit. Equal operands take WIDTH+1.
- Result handshake:
  - res_valid stays high and the result stays stable until res_ready is sampled high.
  - res_ready=1 already on the first DONE cycle completes in one cycle.
  - start_ready returns the edge after the result handshake. There is no accept in the same cycle as the result handshake.
- Throughput: one comparison per latency+1 cycles minimum.
- Slice path is combinational. The cmp_a/cmp_b → cmp_z → cascade reg path must close within one clk period.

## Test plan
- WIDTH=4, EARLY_EXIT=0, A=1010, B=0110 with behavioural slice → cmp_a/cmp_b sequence 1/0,0/1,1/1,0/0. res_valid after 5 edges with gt=1, lt=0, eq=0, err=0.
- EARLY_EXIT=1, A=0011, B=0101 → DONE after 3 edges (differ at bit 2). lt=1, cascade fed 00,00 then latched 01.
- A=B=1111, res_ready held 0 for 4 cycles → eq=1. res_valid and result held stable for all 4 cycles. start_ready=0 until the edge after res_ready=1.
- Slice model forced to return 11 at bit 1 → res_err=1, gt=lt=eq=0 at DONE. A following comparison of 0001 vs 0000 gives gt=1, err=0.
- rst_n pulsed low during the 2nd RUN cycle → all outputs at reset values asynchronously, no res_valid. A next operation 0100 vs 0100 completes with eq=1.
- start_valid held high with new operands during RUN → not accepted. It is accepted on the first IDLE cycle after the result handshake.
